bus_sram_target: RTL and testbench

Bus responder (slave) that maps an on-chip single-port SRAM into the shared-bus address space. It serves burst reads and burst or single writes issued by bus initiators such as the DMA custom-instruction block. It is the target end of the bus protocol: it samples the transaction header, streams read data or absorbs write data through a skid FIFO, and signals bus errors. It sits on the system bus next to the SDRAM controller as a fast scratch memory.

---
 rtl/bus_sram_target.sv | 223 ++++++++++++++++++++++
 tb/tb_bus_sram_target.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_sram_target.sv
// Bus target that maps a single-port SRAM into the shared bus address space.
// Serves burst reads and burst/single writes; writes pass through a 4-entry skid FIFO.
//
// state        | meaning
// IDLE         | waiting for a registered transaction header
// DECODE       | header latched; hit/miss and error decided here
// READ_BURST   | streaming one read word per cycle
// READ_END     | one-cycle endTransactionOut after the last read word
// WRITE_DATA   | absorbing write words into the FIFO
// WRITE_DRAIN  | initiator ended; emptying the FIFO into the SRAM
// ERR_READ     | one-cycle busErrorOut in the first-word slot
// ERR_WAIT_END | write error flagged; discarding data until end
module bus_sram_target #(
  parameter logic [31:0] baseAddress     = 32'h5000_0000,
  parameter int          nrOfWords       = 1024,
  parameter int          writeWaitCycles = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        beginTransactionIn,
  input  logic [31:0] addressDataIn,
  input  logic        readNotWriteIn,
  input  logic [3:0]  byteEnablesIn,
  input  logic [7:0]  burstSizeIn,
  input  logic        dataValidIn,
  input  logic        endTransactionIn,
  output logic [31:0] addressDataOut,
  output logic        dataValidOut,
  output logic        endTransactionOut,
  output logic        busErrorOut,
  output logic        busyOut
);

  localparam int AW = $clog2(nrOfWords);
  localparam logic [32:0] WINDOW_LO = {1'b0, baseAddress};
  localparam logic [32:0] WINDOW_HI = {1'b0, baseAddress} + 33'(4 * nrOfWords);
  localparam logic [12:0] DEPTH13   = 13'(nrOfWords);
  localparam logic [2:0]  WAIT_LOAD = 3'(writeWaitCycles);

  typedef enum logic [2:0] {
    IDLE, DECODE, READ_BURST, READ_END, WRITE_DATA, WRITE_DRAIN, ERR_READ, ERR_WAIT_END
  } state_t;

  state_t state;

  // registered bus inputs
  logic        begin_r, rnw_r, dv_r, end_r;
  logic [31:0] addr_r;
  logic [3:0]  be_r;
  logic [7:0]  burst_r;

  // latched header
  logic [31:0] hdr_addr;
  logic        hdr_rnw;
  logic [3:0]  hdr_be;
  logic [7:0]  hdr_burst;

  logic [AW-1:0] ptr;
  logic [7:0]    rd_left;
  logic [8:0]    acc_cnt;
  logic [2:0]    wait_cnt;

  logic [31:0] fifo_mem [4];
  logic [1:0]  fifo_wr, fifo_rd;
  logic [2:0]  fifo_cnt, fifo_cnt_next;

  logic [31:0] mem [nrOfWords];
  logic [31:0] sram_q;
  logic [AW-1:0] sram_addr;

  logic          hit, err, wr_ok, push, pop;
  logic [AW-1:0] dec_idx;
  logic [12:0]   span;

  // Header decode; the window is aligned to its size, so the low address bits are the word index.
  always_comb begin
    hit     = ({1'b0, hdr_addr} >= WINDOW_LO) && ({1'b0, hdr_addr} < WINDOW_HI);
    dec_idx = hdr_addr[AW+1:2];
    span    = 13'(dec_idx) + 13'(hdr_burst);
    err     = (span >= DEPTH13) || ((hdr_burst != 8'd0) && (hdr_be != 4'hF));
    wr_ok   = hit && !hdr_rnw && !err;
    pop     = !reset && ((state == WRITE_DATA) || (state == WRITE_DRAIN))
              && (fifo_cnt != 3'd0) && (wait_cnt == 3'd0);
    push    = dv_r && (acc_cnt <= {1'b0, hdr_burst})
              && ((state == WRITE_DATA) || ((state == DECODE) && wr_ok))
              && ((fifo_cnt != 3'd4) || pop);
    fifo_cnt_next = fifo_cnt + {2'b00, push} - {2'b00, pop};
    sram_addr = (state == DECODE) ? dec_idx : ptr;
  end

  // Single-port SRAM: byte-masked write from the FIFO head, synchronous read.
  always_ff @(posedge clock) begin
    if (pop) begin
      for (int b = 0; b < 4; b++) begin
        if (hdr_be[b]) mem[sram_addr][8*b +: 8] <= fifo_mem[fifo_rd][8*b +: 8];
      end
    end
    sram_q <= mem[sram_addr];
  end

  // Transaction FSM with input registers, FIFO bookkeeping and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= IDLE;
      begin_r           <= 1'b0;
      rnw_r             <= 1'b0;
      dv_r              <= 1'b0;
      end_r             <= 1'b0;
      addr_r            <= '0;
      be_r              <= '0;
      burst_r           <= '0;
      hdr_addr          <= '0;
      hdr_rnw           <= 1'b0;
      hdr_be            <= '0;
      hdr_burst         <= '0;
      ptr               <= '0;
      rd_left           <= '0;
      acc_cnt           <= '0;
      wait_cnt          <= '0;
      fifo_wr           <= '0;
      fifo_rd           <= '0;
      fifo_cnt          <= '0;
      for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
      addressDataOut    <= '0;
      dataValidOut      <= 1'b0;
      endTransactionOut <= 1'b0;
      busErrorOut       <= 1'b0;
      busyOut           <= 1'b0;
    end else begin
      begin_r <= beginTransactionIn;
      addr_r  <= addressDataIn;
      rnw_r   <= readNotWriteIn;
      be_r    <= byteEnablesIn;
      burst_r <= burstSizeIn;
      dv_r    <= dataValidIn;
      end_r   <= endTransactionIn;

      addressDataOut    <= '0;
      dataValidOut      <= 1'b0;
      endTransactionOut <= 1'b0;
      busErrorOut       <= 1'b0;
      busyOut           <= (fifo_cnt_next >= 3'd2);

      if (push) begin
        fifo_mem[fifo_wr] <= addr_r;
        fifo_wr           <= fifo_wr + 2'd1;
        acc_cnt           <= acc_cnt + 9'd1;
      end
      if (pop) begin
        fifo_rd  <= fifo_rd + 2'd1;
        wait_cnt <= WAIT_LOAD;
      end else if (wait_cnt != 3'd0) begin
        wait_cnt <= wait_cnt - 3'd1;
      end
      fifo_cnt <= fifo_cnt_next;

      case (state)
        IDLE: begin
          if (begin_r) begin
            hdr_addr  <= addr_r;
            hdr_rnw   <= rnw_r;
            hdr_be    <= be_r;
            hdr_burst <= burst_r;
            acc_cnt   <= '0;
            wait_cnt  <= '0;
            state     <= DECODE;
          end
        end
        DECODE: begin
          if (!hit) begin
            state <= IDLE;
          end else if (hdr_rnw) begin
            if (err) begin
              state <= ERR_READ;
            end else begin
              ptr     <= dec_idx + AW'(1);
              rd_left <= hdr_burst;
              state   <= READ_BURST;
            end
          end else if (err) begin
            // an end already seen here would otherwise strand the FSM in ERR_WAIT_END
            busErrorOut <= 1'b1;
            state       <= end_r ? IDLE : ERR_WAIT_END;
          end else begin
            ptr   <= dec_idx;
            state <= end_r ? WRITE_DRAIN : WRITE_DATA;
          end
        end
        READ_BURST: begin
          dataValidOut   <= 1'b1;
          addressDataOut <= sram_q;
          if (rd_left == 8'd0) begin
            state <= READ_END;
          end else begin
            rd_left <= rd_left - 8'd1;
            ptr     <= ptr + AW'(1);
          end
        end
        READ_END: begin
          endTransactionOut <= 1'b1;
          state             <= IDLE;
        end
        WRITE_DATA: begin
          if (pop) ptr <= ptr + AW'(1);
          if (end_r) state <= WRITE_DRAIN;
        end
        WRITE_DRAIN: begin
          if (pop) ptr <= ptr + AW'(1);
          if (fifo_cnt == 3'd0) state <= IDLE;
        end
        ERR_READ: begin
          busErrorOut <= 1'b1;
          state       <= READ_END;
        end
        ERR_WAIT_END: begin
          if (end_r) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_sram_target.sv
// Directed self-checking bench for bus_sram_target.
module tb_bus_sram_target;

  localparam logic [31:0] BASE = 32'h5000_0000;
  localparam int N = 1024;
  localparam int W = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        beginTransactionIn = 1'b0;
  logic [31:0] addressDataIn = '0;
  logic        readNotWriteIn = 1'b0;
  logic [3:0]  byteEnablesIn = '0;
  logic [7:0]  burstSizeIn = '0;
  logic        dataValidIn = 1'b0;
  logic        endTransactionIn = 1'b0;
  logic [31:0] addressDataOut;
  logic        dataValidOut;
  logic        endTransactionOut;
  logic        busErrorOut;
  logic        busyOut;

  bus_sram_target #(
    .baseAddress(BASE), .nrOfWords(N), .writeWaitCycles(W)
  ) dut (
    .clock(clock), .reset(reset),
    .beginTransactionIn(beginTransactionIn), .addressDataIn(addressDataIn),
    .readNotWriteIn(readNotWriteIn), .byteEnablesIn(byteEnablesIn),
    .burstSizeIn(burstSizeIn), .dataValidIn(dataValidIn),
    .endTransactionIn(endTransactionIn), .addressDataOut(addressDataOut),
    .dataValidOut(dataValidOut), .endTransactionOut(endTransactionOut),
    .busErrorOut(busErrorOut), .busyOut(busyOut)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int busy_high_seen = 0;
  logic [31:0] wbuf [0:15];
  logic [31:0] rexp [0:15];

  typedef struct {
    logic        rnw;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;   // write data, or expected read data
    int          mode;   // read: 1 = data expected, 0 = no response
  } vec_t;

  vec_t vt [15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [7:0] burst, input logic [3:0] be,
                           input int nwords, output int err_pulses);
    int sent;
    int cyc;
    err_pulses = 0;
    sent = 0;
    cyc = 0;
    @(negedge clock);
    beginTransactionIn = 1'b1; addressDataIn = addr; readNotWriteIn = 1'b0;
    byteEnablesIn = be; burstSizeIn = burst;
    @(negedge clock);
    beginTransactionIn = 1'b0; addressDataIn = '0;
    while (sent < nwords && cyc < 200) begin
      if (!busyOut) begin
        dataValidIn = 1'b1; addressDataIn = wbuf[sent]; sent++;
      end else begin
        dataValidIn = 1'b0; addressDataIn = '0;
      end
      @(negedge clock);
      cyc++;
      if (busErrorOut) err_pulses++;
      if (busyOut) busy_high_seen++;
    end
    if (cyc >= 200) check("write_timeout", 64'(sent), 64'(nwords));
    dataValidIn = 1'b0; addressDataIn = '0; endTransactionIn = 1'b1;
    @(negedge clock);
    if (busErrorOut) err_pulses++;
    endTransactionIn = 1'b0;
    repeat (30) begin
      @(negedge clock);
      if (busErrorOut) err_pulses++;
    end
  endtask

  // mode: 0 = no response, 1 = burst+1 data words from rexp, 2 = bus error
  task automatic bus_read(input logic [31:0] addr, input logic [7:0] burst, input int mode, input string name);
    int nb;
    logic        ev, ee, er;
    logic [31:0] ed;
    nb = int'(burst);
    @(negedge clock);
    beginTransactionIn = 1'b1; addressDataIn = addr; readNotWriteIn = 1'b1;
    byteEnablesIn = 4'hF; burstSizeIn = burst;
    for (int i = 0; i < nb + 8; i++) begin
      @(negedge clock);
      if (i == 0) begin
        beginTransactionIn = 1'b0; addressDataIn = '0; readNotWriteIn = 1'b0;
      end
      ev = (mode == 1) && (i >= 3) && (i <= 3 + nb);
      ed = ev ? rexp[i-3] : 32'h0;
      ee = ((mode == 1) && (i == 4 + nb)) || ((mode == 2) && (i == 4));
      er = (mode == 2) && (i == 3);
      check(name, {29'h0, dataValidOut, endTransactionOut, busErrorOut, addressDataOut},
                  {29'h0, ev, ee, er, ed});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int bad;

    vt[0]  = '{1'b0, BASE + 32'h100,       4'hF, 32'h1234_5678, 0};
    vt[1]  = '{1'b1, BASE + 32'h100,       4'hF, 32'h1234_5678, 1};
    vt[2]  = '{1'b0, BASE + 32'h100,       4'h3, 32'hAABB_CCDD, 0};
    vt[3]  = '{1'b1, BASE + 32'h100,       4'hF, 32'h1234_CCDD, 1};
    vt[4]  = '{1'b0, BASE + 32'h104,       4'hF, 32'h0000_0000, 0};
    vt[5]  = '{1'b0, BASE + 32'h104,       4'hC, 32'hCAFE_F00D, 0};
    vt[6]  = '{1'b1, BASE + 32'h104,       4'hF, 32'hCAFE_0000, 1};
    vt[7]  = '{1'b0, BASE + 32'(4*(N-1)),  4'hF, 32'hDEAD_BEEF, 0};
    vt[8]  = '{1'b1, BASE + 32'(4*(N-1)),  4'hF, 32'hDEAD_BEEF, 1};
    vt[9]  = '{1'b1, BASE + 32'(4*N),      4'hF, 32'h0,         0};
    vt[10] = '{1'b1, BASE + 32'h103,       4'hF, 32'h1234_CCDD, 1};
    vt[11] = '{1'b0, BASE + 32'h408,       4'hF, 32'h0000_0055, 0};
    vt[12] = '{1'b0, BASE + 32'h500,       4'hF, 32'h0000_0077, 0};
    vt[13] = '{1'b1, BASE - 32'h4,         4'hF, 32'h0,         0};
    vt[14] = '{1'b0, BASE + 32'(4*N),      4'hF, 32'h5555_5555, 0};

    repeat (4) @(negedge clock);
    check("reset_outputs", {27'h0, dataValidOut, endTransactionOut, busErrorOut, busyOut, addressDataOut}, 64'h0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    for (int k = 0; k < 15; k++) begin
      if (vt[k].rnw) begin
        rexp[0] = vt[k].data;
        bus_read(vt[k].addr, 8'd0, vt[k].mode, $sformatf("tbl_rd%0d", k));
      end else begin
        wbuf[0] = vt[k].data;
        bus_write(vt[k].addr, 8'd0, vt[k].be, 1, e);
        check($sformatf("tbl_wr%0d_err", k), 64'(e), 64'd0);
      end
    end

    // 4-word burst write then burst read
    wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33; wbuf[3] = 32'h44;
    bus_write(BASE + 32'h10, 8'd3, 4'hF, 4, e);
    check("burst4_wr_err", 64'(e), 64'd0);
    for (int i = 0; i < 4; i++) rexp[i] = wbuf[i];
    bus_read(BASE + 32'h10, 8'd3, 1, "burst4_rd");

    // read running past the end of the window
    bus_read(BASE + 32'(4*(N-2)), 8'd3, 2, "rd_err_span");

    // miss below the window: nothing at all for 20 cycles, then normal service
    @(negedge clock);
    beginTransactionIn = 1'b1; addressDataIn = BASE - 32'h4; readNotWriteIn = 1'b1; burstSizeIn = 8'd0;
    @(negedge clock);
    beginTransactionIn = 1'b0; addressDataIn = '0; readNotWriteIn = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clock);
      if ({dataValidOut, endTransactionOut, busErrorOut, busyOut} != 4'b0 || addressDataOut != 32'h0) bad++;
    end
    check("miss_quiet", 64'(bad), 64'd0);
    rexp[0] = 32'h1234_CCDD;
    bus_read(BASE + 32'h100, 8'd0, 1, "after_miss_rd");

    // extra words beyond burstSize+1 are dropped
    wbuf[0] = 32'hA0; wbuf[1] = 32'hA1; wbuf[2] = 32'hA2;
    bus_write(BASE + 32'h400, 8'd1, 4'hF, 3, e);
    check("extra_wr_err", 64'(e), 64'd0);
    rexp[0] = 32'hA0; rexp[1] = 32'hA1; rexp[2] = 32'h55;
    bus_read(BASE + 32'h400, 8'd2, 1, "extra_rd");

    // write error from partial byte enables on a burst; SRAM untouched
    wbuf[0] = 32'h99; wbuf[1] = 32'h98;
    bus_write(BASE + 32'h500, 8'd1, 4'h3, 2, e);
    check("wr_err_be", 64'(e), 64'd1);
    rexp[0] = 32'h77;
    bus_read(BASE + 32'h500, 8'd0, 1, "wr_err_be_rd");

    // write error from span at the top of the window
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hBAD0_0000 + 32'(i);
    bus_write(BASE + 32'(4*(N-2)), 8'd3, 4'hF, 4, e);
    check("wr_err_span", 64'(e), 64'd1);
    rexp[0] = 32'hDEAD_BEEF;
    bus_read(BASE + 32'(4*(N-1)), 8'd0, 1, "wr_err_span_rd");

    // throttled 8-word write with back-pressure
    busy_high_seen = 0;
    for (int i = 0; i < 8; i++) wbuf[i] = 32'h1000_0000 + 32'(i * 32'h0101);
    bus_write(BASE + 32'h300, 8'd7, 4'hF, 8, e);
    check("thr_wr_err", 64'(e), 64'd0);
    check("thr_busy_seen", 64'(busy_high_seen != 0), 64'd1);
    check("thr_busy_idle", 64'(busyOut), 64'd0);
    for (int i = 0; i < 8; i++) rexp[i] = wbuf[i];
    bus_read(BASE + 32'h300, 8'd7, 1, "thr_rd");

    // reset in the middle of an 8-word read
    for (int i = 0; i < 8; i++) wbuf[i] = 32'h2000 + 32'(i);
    bus_write(BASE + 32'h200, 8'd7, 4'hF, 8, e);
    check("rst_prep_err", 64'(e), 64'd0);
    @(negedge clock);
    beginTransactionIn = 1'b1; addressDataIn = BASE + 32'h200; readNotWriteIn = 1'b1;
    byteEnablesIn = 4'hF; burstSizeIn = 8'd7;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (i == 0) begin
        beginTransactionIn = 1'b0; addressDataIn = '0; readNotWriteIn = 1'b0;
      end
    end
    check("rst_word2", {31'h0, dataValidOut, addressDataOut}, {31'h0, 1'b1, 32'h2002});
    reset = 1'b1;
    @(negedge clock);
    check("rst_outputs", {27'h0, dataValidOut, endTransactionOut, busErrorOut, busyOut, addressDataOut}, 64'h0);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    rexp[0] = 32'h2000;
    bus_read(BASE + 32'h200, 8'd0, 1, "after_rst_rd");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
